des_gate_eval: RTL

- Task-unit stage that consumes the ttype-0 gate-input-change tasks produced by the DES enqueuer.
- For each task it reads the target gate's state word from L1 and updates the changed input port. It then re-evaluates the gate function, writes the word back with an undo-log entry, and, only if the gate output changed, emits a ttype-1 enqueuer task at ts + gate delay.
- Sits on the same ap_ctrl/AXI-L1/task-stream interface as the other DES task units.

---
 rtl/des_gate_eval.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/des_gate_eval.sv
// des_gate_eval: DES task unit for ttype-0 gate-input-change tasks.
// Reads the gate state word from L1 and updates the changed input. It then
// re-evaluates the gate, logs the old word and writes the new one back.
// When the gate output changes, it emits a ttype-1 task at ts + gate delay.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   ap_start/done/idle/ready     task handshake, task_in sampled in IDLE
//   task_in                      {args, ttype, object, ts}
//   task_out_V_*                 child task stream
//   undo_log_entry*              {gate address, old word} undo log
//   m_axi_l1_V_*                 AXI master to L1 (single-beat 32b)
//   ap_state                     {28'b0, state} for debug
module des_gate_eval #(
  parameter int CORE_ID             = 0,
  parameter int TILE_ID             = 0,
  parameter int TS_WIDTH            = 24,
  parameter int OBJ_WIDTH           = 32,
  parameter int TTYPE_WIDTH         = 4,
  parameter int ARGS_WIDTH          = 32,
  parameter int TQ_WIDTH            = ARGS_WIDTH + TTYPE_WIDTH + OBJ_WIDTH + TS_WIDTH,
  parameter int UNDO_LOG_ADDR_WIDTH = 32,
  parameter int UNDO_LOG_DATA_WIDTH = 32,
  parameter int ID_WIDTH            = 1
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic                                           ap_start,
  output logic                                           ap_done,
  output logic                                           ap_idle,
  output logic                                           ap_ready,
  input  logic [TQ_WIDTH-1:0]                            task_in,
  output logic [TQ_WIDTH-1:0]                            task_out_V_TDATA,
  output logic                                           task_out_V_TVALID,
  input  logic                                           task_out_V_TREADY,
  output logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] undo_log_entry,
  output logic                                           undo_log_entry_ap_vld,
  input  logic                                           undo_log_entry_ap_rdy,
  output logic                                           m_axi_l1_V_ARVALID,
  input  logic                                           m_axi_l1_V_ARREADY,
  output logic [31:0]                                    m_axi_l1_V_ARADDR,
  output logic [7:0]                                     m_axi_l1_V_ARLEN,
  output logic [2:0]                                     m_axi_l1_V_ARSIZE,
  input  logic                                           m_axi_l1_V_RVALID,
  output logic                                           m_axi_l1_V_RREADY,
  input  logic [31:0]                                    m_axi_l1_V_RDATA,
  input  logic                                           m_axi_l1_V_RLAST,
  input  logic [ID_WIDTH-1:0]                            m_axi_l1_V_RID,
  input  logic [1:0]                                     m_axi_l1_V_RRESP,
  output logic                                           m_axi_l1_V_AWVALID,
  input  logic                                           m_axi_l1_V_AWREADY,
  output logic [31:0]                                    m_axi_l1_V_AWADDR,
  output logic [7:0]                                     m_axi_l1_V_AWLEN,
  output logic [2:0]                                     m_axi_l1_V_AWSIZE,
  output logic                                           m_axi_l1_V_WVALID,
  input  logic                                           m_axi_l1_V_WREADY,
  output logic [31:0]                                    m_axi_l1_V_WDATA,
  output logic [3:0]                                     m_axi_l1_V_WSTRB,
  output logic                                           m_axi_l1_V_WLAST,
  input  logic                                           m_axi_l1_V_BVALID,
  output logic                                           m_axi_l1_V_BREADY,
  input  logic [1:0]                                     m_axi_l1_V_BRESP,
  input  logic [ID_WIDTH-1:0]                            m_axi_l1_V_BID,
  output logic [31:0]                                    ap_state
);

  typedef enum logic [3:0] {
    IDLE, READ_BASE, WAIT_BASE, READ_GATE, WAIT_GATE, EVAL,
    UNDO, WR_ADDR, WR_DATA, WAIT_B, ENQ, FINISH
  } state_t;

  localparam int ARGS_LSB = TS_WIDTH + OBJ_WIDTH + TTYPE_WIDTH;

  state_t                 state_q, state_d;
  logic [OBJ_WIDTH-1:0]   gate_id_q, gate_id_d;
  logic                   port_q, port_d;
  logic [1:0]             val_q, val_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [31:0]            base_gate_q, base_gate_d;
  logic                   initialized_q, initialized_d;
  logic [31:0]            old_word_q, old_word_d;
  logic [31:0]            new_word_q, new_word_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;

  logic [31:0]            gate_addr;
  logic [1:0]             eval_out;
  logic [TS_WIDTH:0]      ts_sum;
  logic [TS_WIDTH-1:0]    child_ts;

  // Values: bit 1 set means X; results are only ever 0, 1 or 2.
  function automatic logic [1:0] eval_gate(input logic [3:0] gtype,
                                           input logic [1:0] a,
                                           input logic [1:0] b);
    logic [1:0] r;
    logic       ax, bx;
    ax = a[1];
    bx = b[1];
    case (gtype)
      4'd1: r = ax ? 2'd2 : {1'b0, ~a[0]};
      4'd2, 4'd5: begin
        if ((!ax && !a[0]) || (!bx && !b[0])) r = 2'd0;
        else if (ax || bx)                    r = 2'd2;
        else                                  r = 2'd1;
      end
      4'd3, 4'd6: begin
        if ((!ax && a[0]) || (!bx && b[0])) r = 2'd1;
        else if (ax || bx)                  r = 2'd2;
        else                                r = 2'd0;
      end
      4'd4, 4'd7: r = (ax || bx) ? 2'd2 : {1'b0, a[0] ^ b[0]};
      default:    r = ax ? 2'd2 : {1'b0, a[0]};
    endcase
    // NAND/NOR/XNOR invert the base result; X stays X.
    if ((gtype == 4'd5 || gtype == 4'd6 || gtype == 4'd7) && r != 2'd2)
      r = {1'b0, ~r[0]};
    return r;
  endfunction

  assign gate_addr = base_gate_q + {gate_id_q[29:0], 2'b00};
  assign eval_out  = eval_gate(new_word_q[9:6], new_word_q[1:0], new_word_q[3:2]);
  assign ts_sum    = {1'b0, ts_q} + {{(TS_WIDTH-15){1'b0}}, old_word_q[25:10]};
  assign child_ts  = ts_sum[TS_WIDTH] ? {TS_WIDTH{1'b1}} : ts_sum[TS_WIDTH-1:0];

  assign m_axi_l1_V_ARLEN   = 8'd0;
  assign m_axi_l1_V_ARSIZE  = 3'b010;
  assign m_axi_l1_V_AWADDR  = gate_addr;
  assign m_axi_l1_V_AWLEN   = 8'd0;
  assign m_axi_l1_V_AWSIZE  = 3'b010;
  assign m_axi_l1_V_WDATA   = new_word_q;
  assign m_axi_l1_V_WSTRB   = 4'hF;
  assign m_axi_l1_V_WLAST   = 1'b1;
  assign m_axi_l1_V_BREADY  = 1'b1;
  assign undo_log_entry     = {gate_addr, old_word_q};
  assign task_out_V_TDATA   = {{ARGS_WIDTH{1'b0}}, TTYPE_WIDTH'(1), gate_id_q, child_ts};
  assign ap_idle            = (state_q == IDLE);
  assign ap_ready           = (state_q == IDLE);
  assign ap_done            = (state_q == FINISH);
  assign ap_state           = {28'd0, state_q};

  always_comb begin
    state_d               = state_q;
    gate_id_d             = gate_id_q;
    port_d                = port_q;
    val_d                 = val_q;
    ts_d                  = ts_q;
    base_gate_d           = base_gate_q;
    initialized_d         = initialized_q;
    old_word_d            = old_word_q;
    new_word_d            = new_word_q;
    aw_done_d             = aw_done_q;
    w_done_d              = w_done_q;
    m_axi_l1_V_ARVALID    = 1'b0;
    m_axi_l1_V_ARADDR     = 32'd0;
    m_axi_l1_V_RREADY     = 1'b0;
    m_axi_l1_V_AWVALID    = 1'b0;
    m_axi_l1_V_WVALID     = 1'b0;
    undo_log_entry_ap_vld = 1'b0;
    task_out_V_TVALID     = 1'b0;
    case (state_q)
      IDLE: if (ap_start) begin
        gate_id_d = task_in[TS_WIDTH +: OBJ_WIDTH];
        val_d     = task_in[ARGS_LSB +: 2];
        port_d    = task_in[ARGS_LSB + 2];
        ts_d      = task_in[TS_WIDTH-1:0];
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = initialized_q ? READ_GATE : READ_BASE;
      end
      READ_BASE: begin
        m_axi_l1_V_ARVALID = 1'b1;
        m_axi_l1_V_ARADDR  = 32'd10 << 2;
        if (m_axi_l1_V_ARREADY) state_d = WAIT_BASE;
      end
      WAIT_BASE: begin
        m_axi_l1_V_RREADY = 1'b1;
        if (m_axi_l1_V_RVALID) begin
          base_gate_d   = {m_axi_l1_V_RDATA[29:0], 2'b00};
          initialized_d = 1'b1;
          state_d       = READ_GATE;
        end
      end
      READ_GATE: begin
        m_axi_l1_V_ARVALID = 1'b1;
        m_axi_l1_V_ARADDR  = gate_addr;
        if (m_axi_l1_V_ARREADY) state_d = WAIT_GATE;
      end
      WAIT_GATE: begin
        m_axi_l1_V_RREADY = 1'b1;
        if (m_axi_l1_V_RVALID) begin
          old_word_d = m_axi_l1_V_RDATA;
          new_word_d = m_axi_l1_V_RDATA;
          if (port_q) new_word_d[3:2] = val_q;
          else        new_word_d[1:0] = val_q;
          state_d = EVAL;
        end
      end
      EVAL: begin
        new_word_d[5:4] = eval_out;
        state_d = ({new_word_q[31:6], eval_out, new_word_q[3:0]} == old_word_q) ? FINISH : UNDO;
      end
      UNDO: begin
        undo_log_entry_ap_vld = 1'b1;
        if (undo_log_entry_ap_rdy) state_d = WR_ADDR;
      end
      // W is offered alongside AW so the slave may take either first.
      WR_ADDR: begin
        m_axi_l1_V_AWVALID = !aw_done_q;
        m_axi_l1_V_WVALID  = !w_done_q;
        aw_done_d = aw_done_q | m_axi_l1_V_AWREADY;
        w_done_d  = w_done_q | m_axi_l1_V_WREADY;
        if (aw_done_d) state_d = w_done_d ? WAIT_B : WR_DATA;
      end
      WR_DATA: begin
        m_axi_l1_V_WVALID = !w_done_q;
        w_done_d = w_done_q | m_axi_l1_V_WREADY;
        if (w_done_d) state_d = WAIT_B;
      end
      WAIT_B: if (m_axi_l1_V_BVALID)
        state_d = (new_word_q[5:4] != old_word_q[5:4]) ? ENQ : FINISH;
      ENQ: begin
        task_out_V_TVALID = 1'b1;
        if (task_out_V_TREADY) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      gate_id_q     <= '0;
      port_q        <= 1'b0;
      val_q         <= 2'd0;
      ts_q          <= '0;
      base_gate_q   <= 32'd0;
      initialized_q <= 1'b0;
      old_word_q    <= 32'd0;
      new_word_q    <= 32'd0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gate_id_q     <= gate_id_d;
      port_q        <= port_d;
      val_q         <= val_d;
      ts_q          <= ts_d;
      base_gate_q   <= base_gate_d;
      initialized_q <= initialized_d;
      old_word_q    <= old_word_d;
      new_word_q    <= new_word_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
    end
  end

  // Debug indices, response codes and unused task fields are not needed.
  logic unused_ok;
  assign unused_ok = ^{CORE_ID, TILE_ID, m_axi_l1_V_RLAST, m_axi_l1_V_RID,
                       m_axi_l1_V_RRESP, m_axi_l1_V_BRESP, m_axi_l1_V_BID,
                       task_in[TQ_WIDTH-1:ARGS_LSB+3],
                       task_in[ARGS_LSB-1:TS_WIDTH+OBJ_WIDTH]};

endmodule
